clock_divider_ctrl: RTL and testbench
=====================================

Name: clock_divider_ctrl

Overview:
Run-time controller for the team's divide-by-2N clock generation. It loads a programmable half-period through a valid/ready config port and starts and stops the divided output glitch-free. It supports continuous or fixed-length burst operation and emits a one-cycle tick on each rising edge of clock_out. It sits between the control FSM / switch logic and the counter/display blocks that consume the divided clock or tick.

Parameters:
DIV_WIDTH, 16, width of half-period and internal counter
BURST_WIDTH, 8, width of burst length and tick_count
DEFAULT_HALF, 2, half-period (input cycles) after reset; 2 gives the standard divide-by-4

Ports:
clock_in  input  1  system clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
cfg_valid  input  1  config request
cfg_ready  output  1  config can be accepted this cycle
cfg_half_period  input  DIV_WIDTH  new half-period in clock_in cycles; 0 treated as 1
cfg_burst  input  BURST_WIDTH  rising edges per run; 0 = continuous
start  input  1  level sampled; begins a run from IDLE
stop  input  1  level sampled; ends a run glitch-free
clock_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse coincident with each 0->1 of clock_out
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when a burst completes
tick_count  output  BURST_WIDTH  rising edges since last start; wraps in continuous mode

Behaviour:
- Reset (reset_n low at a posedge): state IDLE; clock_out=0, tick=0, done=0, busy=0, tick_count=0, counter=0; active half=DEFAULT_HALF, active burst=0; shadow config empty; cfg_ready=1. Overrides all other inputs, including mid-run (no done pulse).
- States: IDLE, RUN, STOPPING.
- Config accept = cfg_valid && cfg_ready.
  - IDLE: cfg_ready=1; the accepted value is written to the active registers at that edge.
  - RUN/STOPPING: cfg_ready = shadow empty. The accepted value goes to the one-deep shadow. It is applied to active at the next falling toggle of clock_out (period boundary), the counter restarts at 0, and the shadow empties.
  - If an accept coincides with a boundary edge, the new value is applied directly at that edge.
- IDLE -> RUN: start=1 at an edge. Counter=0, clock_out=0, tick_count=0. start is ignored outside IDLE. stop is ignored in IDLE.
- RUN counting:
  - At each edge, if counter==half-1: counter<=0 and clock_out toggles. Otherwise counter<=counter+1.
  - Output period = 2*half clock_in cycles, 50% duty. The first rising edge occurs at the half-th edge after the start edge.
- Rising toggle: tick<=1 for one cycle and tick_count increments, both in the same edge as clock_out<=1.
- Burst (active burst B != 0): at the falling toggle following the B-th rising edge, clock_out<=0, state<=IDLE, done<=1 for one cycle, busy drops that same edge. tick_count holds B until the next start.
- stop in RUN:
  - If clock_out==0: -> IDLE at that edge; counter cleared; the low phase is truncated with no glitch.
  - If clock_out==1: -> STOPPING. The high phase completes, then at the falling toggle -> IDLE.
  - No done pulse on stop. stop and start together in RUN: stop wins.
- STOPPING: counting continues; a burst completing at the same falling edge still pulses done.
- The shadow config persists across stop; it is applied on entering IDLE.
- clock_out never changes except via toggle or reset. No high phase is shorter than the active half.

Test Plan:
1. Reset, then start=1 for 1 cycle with default half=2 -> clock_out rises at edges 2, 6, 10… after start (period 4); tick pulses at each rise; busy=1; tick_count 1, 2, 3…
2. In IDLE, cfg half=3, burst=2, then start -> rises at +3 and +9, falls at +12 with done=1 for 1 cycle; busy=0 at +12; tick_count=2; clock_out stays 0.
3. Running half=2; accept cfg half=5 mid high phase -> cfg_ready=0 until the next falling edge; the next period is 10 cycles; the old period completes unchanged.
4. stop asserted 1 cycle into the high phase -> clock_out stays high for the full 2 cycles, then 0; state IDLE; no done.
5. stop asserted during the low phase -> IDLE next edge, clock_out remains 0; a following start restarts the first rise at +2 with tick_count=1.
6. reset_n low for 1 cycle mid high phase -> clock_out=0, busy=0, tick_count=0, half=2, the pending shadow discarded; cfg_half_period=0 then gives period 2.

Source files
------------

// File: rtl/clock_divider_ctrl_if.sv
// rtl/clock_divider_ctrl_if.sv - config handshake bundle for clock_divider_ctrl
interface clock_divider_ctrl_if #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [DIV_WIDTH-1:0]   cfg_half_period;
    logic [BURST_WIDTH-1:0] cfg_burst;

    modport master (output cfg_valid, cfg_half_period, cfg_burst, input cfg_ready);
    modport slave  (input cfg_valid, cfg_half_period, cfg_burst, output cfg_ready);
endinterface

// File: rtl/clock_divider_ctrl.sv
// rtl/clock_divider_ctrl.sv - run-time controller for a glitch-free divide-by-2N clock
// Config lands directly in IDLE, otherwise through a one-deep shadow applied at a period boundary.
module clock_divider_ctrl #(
    parameter int DIV_WIDTH    = 16,
    parameter int BURST_WIDTH  = 8,
    parameter int DEFAULT_HALF = 2
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    clock_divider_ctrl_if.slave    cfg,
    input  logic                   start,
    input  logic                   stop,
    output logic                   clock_out,
    output logic                   tick,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] tick_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_e;

    localparam logic [DIV_WIDTH-1:0] RESET_HALF =
        (DEFAULT_HALF < 1) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_HALF);

    state_e                 state_q;
    logic [DIV_WIDTH-1:0]   counter_q;
    logic [DIV_WIDTH-1:0]   half_q;
    logic [DIV_WIDTH-1:0]   shadow_half_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic [BURST_WIDTH-1:0] shadow_burst_q;
    logic [BURST_WIDTH-1:0] tick_count_q;
    logic                   shadow_valid_q;
    logic                   clock_out_q;
    logic                   tick_q;
    logic                   done_q;

    logic [DIV_WIDTH-1:0]   cfg_half_norm;
    logic                   running;
    logic                   accept;
    logic                   at_limit;
    logic                   trunc_evt;
    logic                   rise_evt;
    logic                   fall_evt;
    logic                   burst_hit;
    logic                   leave_evt;
    logic                   boundary;

    assign cfg_half_norm = (cfg.cfg_half_period == '0) ? DIV_WIDTH'(1) : cfg.cfg_half_period;
    assign running       = (state_q != S_IDLE);
    assign cfg.cfg_ready = !running || !shadow_valid_q;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign at_limit      = (counter_q == half_q - DIV_WIDTH'(1));

    // A stop during the low phase cuts it short; nothing toggles, so no runt pulse.
    assign trunc_evt = (state_q == S_RUN) && stop && !clock_out_q;
    assign rise_evt  = running && !trunc_evt && at_limit && !clock_out_q;
    assign fall_evt  = running && at_limit && clock_out_q;
    assign burst_hit = (burst_q != '0) && (tick_count_q == burst_q);
    assign leave_evt = trunc_evt || (fall_evt && (burst_hit || (state_q == S_STOPPING) || stop));
    assign boundary  = trunc_evt || fall_evt;

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            counter_q      <= '0;
            half_q         <= RESET_HALF;
            burst_q        <= '0;
            shadow_half_q  <= '0;
            shadow_burst_q <= '0;
            shadow_valid_q <= 1'b0;
            tick_count_q   <= '0;
            clock_out_q    <= 1'b0;
            tick_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (!running) begin
                if (accept) begin
                    half_q  <= cfg_half_norm;
                    burst_q <= cfg.cfg_burst;
                end
                if (start) begin
                    state_q      <= S_RUN;
                    counter_q    <= '0;
                    clock_out_q  <= 1'b0;
                    tick_count_q <= '0;
                end
            end else begin
                counter_q <= (trunc_evt || at_limit) ? '0 : counter_q + DIV_WIDTH'(1);
                if (rise_evt || fall_evt) begin
                    clock_out_q <= !clock_out_q;
                end
                if (rise_evt) begin
                    tick_q       <= 1'b1;
                    tick_count_q <= tick_count_q + BURST_WIDTH'(1);
                end
                if ((state_q == S_RUN) && stop && clock_out_q) begin
                    state_q <= S_STOPPING;
                end
                if (leave_evt) begin
                    state_q <= S_IDLE;
                    done_q  <= fall_evt && burst_hit;
                end
                // New config only takes effect where a period ends, so the current one is never distorted.
                if (boundary) begin
                    if (accept) begin
                        half_q  <= cfg_half_norm;
                        burst_q <= cfg.cfg_burst;
                    end else if (shadow_valid_q) begin
                        half_q  <= shadow_half_q;
                        burst_q <= shadow_burst_q;
                    end
                    shadow_valid_q <= 1'b0;
                end else if (accept) begin
                    shadow_half_q  <= cfg_half_norm;
                    shadow_burst_q <= cfg.cfg_burst;
                    shadow_valid_q <= 1'b1;
                end
            end
        end
    end

    assign clock_out  = clock_out_q;
    assign tick       = tick_q;
    assign busy       = running;
    assign done       = done_q;
    assign tick_count = tick_count_q;
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb/tb_clock_divider_ctrl.sv - self-checking bench for clock_divider_ctrl
module tb_clock_divider_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       clock_out;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] tick_count;

    int n_total = 0;
    int n_pass  = 0;

    clock_divider_ctrl_if #(.DIV_WIDTH(16), .BURST_WIDTH(8)) cif ();

    clock_divider_ctrl #(.DIV_WIDTH(16), .BURST_WIDTH(8), .DEFAULT_HALF(2)) dut (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .cfg        (cif),
        .start      (start),
        .stop       (stop),
        .clock_out  (clock_out),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic int norm_half(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    // Model: position n cycles into a segment of constant half h gives the
    // waveform directly; a rise sits at n mod 2h == h, a fall at n mod 2h == 0.
    int         cyc = 0;
    int         m_seg;
    int         m_half;
    logic [7:0] m_burst;
    logic [7:0] m_rises;
    int         m_sh_half;
    logic [7:0] m_sh_burst;
    logic       m_sh_v;
    logic       m_run, m_stopping, m_clk, m_tick, m_done;
    logic       model_on = 1'b0;

    always @(posedge clk) begin
        int   n;
        int   h2;
        logic acc, fall, to_idle;
        cyc++;
        m_tick = 1'b0;
        m_done = 1'b0;
        if (!reset_n) begin
            m_run = 0; m_stopping = 0; m_clk = 0; m_rises = 0;
            m_half = 2; m_burst = 0; m_sh_v = 0; m_sh_half = 0; m_sh_burst = 0; m_seg = cyc;
        end else if (!m_run) begin
            if (cif.cfg_valid) begin
                m_half  = norm_half(cif.cfg_half_period);
                m_burst = cif.cfg_burst;
            end
            if (start) begin
                m_run = 1; m_stopping = 0; m_seg = cyc; m_clk = 0; m_rises = 0;
            end
        end else begin
            acc     = cif.cfg_valid && !m_sh_v;
            n       = cyc - m_seg;
            h2      = 2 * m_half;
            to_idle = 0;
            fall    = 0;
            if (stop && !m_stopping && !m_clk) begin
                to_idle = 1;
            end else begin
                if (stop && m_clk) m_stopping = 1;
                if (n % h2 == m_half) begin
                    m_clk = 1; m_tick = 1; m_rises = m_rises + 8'd1;
                end else if (n % h2 == 0) begin
                    fall  = 1;
                    m_clk = 0;
                    if (m_burst != 0 && m_rises == m_burst) begin
                        to_idle = 1; m_done = 1;
                    end else if (m_stopping) begin
                        to_idle = 1;
                    end
                end
            end
            if (to_idle || fall) begin
                if (acc) begin
                    m_half = norm_half(cif.cfg_half_period); m_burst = cif.cfg_burst; m_seg = cyc;
                end else if (m_sh_v) begin
                    m_half = m_sh_half; m_burst = m_sh_burst; m_seg = cyc;
                end
                m_sh_v = 0;
            end else if (acc) begin
                m_sh_half = norm_half(cif.cfg_half_period); m_sh_burst = cif.cfg_burst; m_sh_v = 1;
            end
            if (to_idle) begin
                m_run = 0; m_stopping = 0;
            end
        end
        model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_clock_out", clock_out, m_clk);
            chk("m_tick", tick, m_tick);
            chk("m_done", done, m_done);
            chk("m_busy", busy, m_run);
            chk("m_tick_count", tick_count, m_rises);
            chk("m_cfg_ready", cif.cfg_ready, !m_run || !m_sh_v);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] h, input logic [7:0] b);
        cif.cfg_valid = 1'b1; cif.cfg_half_period = h; cif.cfg_burst = b;
        step();
        cif.cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_half_period = 16'd0; cif.cfg_burst = 8'd0;
        repeat (3) step();
        chk("rst_clock_out", clock_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_cfg_ready", cif.cfg_ready, 1);
        reset_n = 1'b1;

        // default half=2: rises at +2, +6, +10
        do_start();
        chk("t1_busy", busy, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2) begin
                chk("t1_rise2", clock_out, 1); chk("t1_tick2", tick, 1); chk("t1_tc2", tick_count, 1);
            end
            if (k == 4) chk("t1_fall4", clock_out, 0);
            if (k == 6) chk("t1_tc6", tick_count, 2);
            if (k == 10) begin chk("t1_rise10", clock_out, 1); chk("t1_tc10", tick_count, 3); end
        end

        // stop one cycle into the high phase
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_still_high", clock_out, 1);
        chk("t4_busy", busy, 1);
        step();
        chk("t4_low", clock_out, 0);
        chk("t4_idle", busy, 0);
        chk("t4_no_done", done, 0);
        repeat (2) step();

        // burst of 2 at half=3
        set_cfg(16'd3, 8'd2);
        do_start();
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 3) begin chk("t2_rise3", clock_out, 1); chk("t2_tc3", tick_count, 1); end
            if (k == 6) chk("t2_fall6", clock_out, 0);
            if (k == 9) begin chk("t2_rise9", clock_out, 1); chk("t2_tc9", tick_count, 2); end
            if (k == 11) begin chk("t2_busy11", busy, 1); chk("t2_done11", done, 0); end
            if (k == 12) begin
                chk("t2_fall12", clock_out, 0); chk("t2_done12", done, 1);
                chk("t2_busy12", busy, 0); chk("t2_tc12", tick_count, 2);
            end
            if (k == 13) begin chk("t2_done13", done, 0); chk("t2_tc13", tick_count, 2); end
            if (k == 14) chk("t2_low14", clock_out, 0);
        end

        // live reconfigure half 2 -> 5 mid high phase
        set_cfg(16'd2, 8'd0);
        do_start();
        repeat (2) step();
        chk("t3_high2", clock_out, 1);
        set_cfg(16'd5, 8'd0);
        chk("t3_ready_low", cif.cfg_ready, 0);
        chk("t3_high3", clock_out, 1);
        step();
        chk("t3_fall4", clock_out, 0);
        chk("t3_ready_back", cif.cfg_ready, 1);
        for (int k = 5; k <= 25; k++) begin
            step();
            if (k == 8) chk("t3_low8", clock_out, 0);
            if (k == 9) begin chk("t3_rise9", clock_out, 1); chk("t3_tick9", tick, 1); end
            if (k == 13) chk("t3_high13", clock_out, 1);
            if (k == 14) chk("t3_fall14", clock_out, 0);
            if (k == 19) begin chk("t3_rise19", clock_out, 1); chk("t3_tc19", tick_count, 3); end
        end

        // stop during low phase, then restart at half=2
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_idle", busy, 0);
        chk("t5_low", clock_out, 0);
        chk("t5_no_done", done, 0);
        set_cfg(16'd2, 8'd0);
        do_start();
        step();
        chk("t5_low1", clock_out, 0);
        step();
        chk("t5_rise2", clock_out, 1);
        chk("t5_tc2", tick_count, 1);

        // reset mid high phase with a pending shadow
        set_cfg(16'd7, 8'd0);
        chk("t6_pending", cif.cfg_ready, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_clk", clock_out, 0);
        chk("t6_busy", busy, 0);
        chk("t6_tc", tick_count, 0);
        chk("t6_ready", cif.cfg_ready, 1);
        chk("t6_done", done, 0);
        do_start();
        repeat (2) step();
        chk("t6_default_rise2", clock_out, 1);
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t6_stopped", busy, 0);
        set_cfg(16'd0, 8'd0);
        do_start();
        step();
        chk("t6_h0_rise1", clock_out, 1);
        step();
        chk("t6_h0_fall2", clock_out, 0);
        step();
        chk("t6_h0_rise3", clock_out, 1);
        chk("t6_h0_tc3", tick_count, 2);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
